div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
Controller that sequences the multi-cycle divider attached to the execute stage.
- Detects a DIV/DIVU in E and latches its operands.
- Drives the divider start/annul/signed controls and holds the pipeline via stall_div.
- Presents the 64-bit {hi,lo} result to the HI/LO write path.
- Handles divide-by-zero, E-stage flush, downstream hold and a watchdog timeout.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH.
TIMEOUT, 40, max cycles in BUSY before the watchdog aborts the divide.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
div_reqE  in  1  a divide instruction is in E (qualified by decode)
div_signedE  in  1  1 = DIV, 0 = DIVU
srcaE  in  WIDTH  forwarded dividend
srcbE  in  WIDTH  forwarded divisor
flushE  in  1  kill the E-stage instruction this cycle
pipe_holdE  in  1  E cannot advance (downstream stall)
div_ready_i  in  1  divider result valid
div_result_i  in  2*WIDTH  divider result {remainder, quotient}
div_start_o  out  1  divider start, level
div_annul_o  out  1  divider abort, one-cycle pulse
div_signed_o  out  1  latched signed flag
div_opa_o  out  WIDTH  latched dividend
div_opb_o  out  WIDTH  latched divisor
stall_div  out  1  stall F/D/E
hilo_res_o  out  2*WIDTH  {hi,lo} result
hilo_valid_o  out  1  hilo_res_o valid for the instruction in E
timeout_o  out  1  sticky watchdog error

Behaviour:
- States: IDLE, BUSY, DONE. Reset forces IDLE. On reset:
  - all outputs 0, counter 0, latches 0, timeout_o 0.
  - reset mid-operation abandons the divide; no annul pulse is emitted.
- stall_div (combinational) = (IDLE & div_reqE & ~flushE) | BUSY. It is asserted in the same cycle the divide is detected.
- IDLE, when div_reqE & ~flushE:
  - Latch srcaE, srcbE and div_signedE into div_opa_o, div_opb_o and div_signed_o.
  - If srcbE == 0: skip the divider, load hilo_res_o = {srcaE, all-ones}, go to DONE.
  - Otherwise: clear the counter and go to BUSY.
- IDLE, otherwise: no action. div_reqE with flushE is ignored.
- BUSY:
  - div_start_o = 1 for the whole state; the counter increments each cycle.
  - Priority in BUSY, highest first:
    1. flushE: div_annul_o = 1 for the next cycle, go to IDLE, no result.
    2. div_ready_i: capture div_result_i into hilo_res_o, go to DONE.
    3. counter == TIMEOUT-1: set timeout_o, pulse div_annul_o, hilo_res_o = 0, go to DONE so the pipeline is released.
- DONE:
  - hilo_valid_o = 1 and stall_div = 0.
  - Stay in DONE while pipe_holdE; outputs are held stable.
  - If ~pipe_holdE (the instruction leaves E): go to IDLE; hilo_valid_o drops the next cycle.
  - If flushE: go to IDLE and drop hilo_valid_o the next cycle.
- Back-to-back divides: a second divide present in E in the first IDLE cycle after DONE starts immediately. The old result is never reused.
- Latency: a non-zero divide of divider latency L gives stall_div high for L+1 cycles and hilo_valid_o 1 cycle after div_ready_i. Divide-by-zero gives a 1-cycle stall.
- div_ready_i outside BUSY is ignored.
- The divider is never started in IDLE or DONE.
- timeout_o is cleared only by reset.

Test Plan:
- DIVU 100/7, model divider L=34: stall_div high 35 cycles, div_start_o high throughout BUSY, hilo_res_o={2,14}, hilo_valid_o 1 cycle.
- DIV -7/2 signed: div_signed_o=1, hilo_res_o={32'hFFFFFFFF, 32'hFFFFFFFD}.
- DIVU 5/0: no div_start_o, stall 1 cycle, hilo_res_o={5, 32'hFFFFFFFF}.
- flushE at BUSY cycle 10: div_annul_o pulses once, IDLE next, hilo_valid_o never asserts; next DIVU 9/3 gives {0,3}.
- pipe_holdE high 3 cycles in DONE: hilo_valid_o/hilo_res_o stable 4 cycles, then IDLE. Two consecutive divides both return correct results.
- Divider never ready, TIMEOUT=40: timeout_o set after 40 BUSY cycles, annul pulses, stall released; reset asserted mid-BUSY returns all outputs to 0 asynchronously.

Source files
------------

// File: rtl/div_sequencer.sv
// Sequencer for the multi-cycle divider in the execute stage: latches operands,
// drives start/annul, stalls the pipe and hands the {hi,lo} result to HI/LO.
module div_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               div_reqE,
  input  logic               div_signedE,
  input  logic [WIDTH-1:0]   srcaE,
  input  logic [WIDTH-1:0]   srcbE,
  input  logic               flushE,
  input  logic               pipe_holdE,
  input  logic               div_ready_i,
  input  logic [2*WIDTH-1:0] div_result_i,
  output logic               div_start_o,
  output logic               div_annul_o,
  output logic               div_signed_o,
  output logic [WIDTH-1:0]   div_opa_o,
  output logic [WIDTH-1:0]   div_opb_o,
  output logic               stall_div,
  output logic [2*WIDTH-1:0] hilo_res_o,
  output logic               hilo_valid_o,
  output logic               timeout_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     opa_q;
  logic [WIDTH-1:0]     opb_q;
  logic                 signed_q;
  logic                 start_q;
  logic                 annul_q;
  logic [2*WIDTH-1:0]   res_q;
  logic                 valid_q;
  logic                 timeout_q;
  logic                 accept;

  assign accept = div_reqE & ~flushE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      signed_q  <= 1'b0;
      start_q   <= 1'b0;
      annul_q   <= 1'b0;
      res_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      annul_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            opa_q    <= srcaE;
            opb_q    <= srcbE;
            signed_q <= div_signedE;
            // Divide-by-zero bypasses the divider with a fixed architectural result
            if (srcbE == '0) begin
              res_q   <= {srcaE, {WIDTH{1'b1}}};
              valid_q <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q   <= '0;
              start_q <= 1'b1;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + CW'(1);
          if (flushE) begin
            annul_q <= 1'b1;
            start_q <= 1'b0;
            state_q <= IDLE;
          end else if (div_ready_i) begin
            res_q   <= div_result_i;
            valid_q <= 1'b1;
            start_q <= 1'b0;
            state_q <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            // Watchdog: abort the divider but still release the pipe via DONE
            timeout_q <= 1'b1;
            annul_q   <= 1'b1;
            res_q     <= '0;
            valid_q   <= 1'b1;
            start_q   <= 1'b0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (flushE || !pipe_holdE) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          start_q <= 1'b0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Gated by reset so every output reads 0 while reset is held
  always_comb begin
    stall_div = 1'b0;
    if (!reset) begin
      stall_div = ((state_q == IDLE) & accept) | (state_q == BUSY);
    end
  end

  assign div_start_o  = start_q;
  assign div_annul_o  = annul_q;
  assign div_signed_o = signed_q;
  assign div_opa_o    = opa_q;
  assign div_opb_o    = opb_q;
  assign hilo_res_o   = res_q;
  assign hilo_valid_o = valid_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a fixed-latency divider model and a
// queue of expected {hi,lo} results.
module tb_div_sequencer;

  localparam int unsigned W   = 32;
  localparam int unsigned TO  = 40;
  localparam int unsigned LAT = 34;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          div_reqE = 1'b0;
  logic          div_signedE = 1'b0;
  logic [W-1:0]  srcaE = '0;
  logic [W-1:0]  srcbE = '0;
  logic          flushE = 1'b0;
  logic          pipe_holdE = 1'b0;
  logic          div_ready_i;
  logic [2*W-1:0] div_result_i;
  logic          div_start_o;
  logic          div_annul_o;
  logic          div_signed_o;
  logic [W-1:0]  div_opa_o;
  logic [W-1:0]  div_opb_o;
  logic          stall_div;
  logic [2*W-1:0] hilo_res_o;
  logic          hilo_valid_o;
  logic          timeout_o;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];
  logic        ready_en = 1'b1;
  logic [7:0]  dcnt;

  div_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .div_reqE(div_reqE), .div_signedE(div_signedE),
    .srcaE(srcaE), .srcbE(srcbE), .flushE(flushE), .pipe_holdE(pipe_holdE),
    .div_ready_i(div_ready_i), .div_result_i(div_result_i),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o),
    .div_signed_o(div_signed_o), .div_opa_o(div_opa_o), .div_opb_o(div_opb_o),
    .stall_div(stall_div), .hilo_res_o(hilo_res_o),
    .hilo_valid_o(hilo_valid_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic [31:0] q, r;
    if (b == 32'd0) return '0;
    if (s) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Divider model: ready on the LAT-th consecutive cycle of start
  always @(posedge clk or posedge reset) begin
    if (reset) dcnt <= '0;
    else if (!div_start_o) dcnt <= '0;
    else dcnt <= dcnt + 8'd1;
  end
  assign div_ready_i  = ready_en && div_start_o && (dcnt == 8'(LAT - 1));
  assign div_result_i = ref_div(div_opa_o, div_opb_o, div_signed_o);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] exp, input int exp_stall, input int hold,
                        input logic exp_annul, input string tag);
    int stall_cnt;
    int start_bad;
    logic [63:0] r0;
    logic [63:0] e;
    exp_q.push_back(exp);
    div_reqE = 1'b1; srcaE = a; srcbE = b; div_signedE = s;
    pipe_holdE = (hold > 0);
    #1;
    check({tag, "_nostart_idle"}, 64'(div_start_o), 64'd0);
    stall_cnt = 0;
    start_bad = 0;
    for (int i = 0; i < 200 && stall_div; i++) begin
      stall_cnt++;
      tick();
      if (stall_div && !div_start_o) start_bad++;
    end
    check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_stall));
    check({tag, "_start_level"}, 64'(start_bad), 64'd0);
    check({tag, "_valid"}, 64'(hilo_valid_o), 64'd1);
    check({tag, "_annul"}, 64'(div_annul_o), 64'(exp_annul));
    check({tag, "_ops"}, {div_signed_o, div_opa_o, div_opb_o}, {s, a, b});
    e = (exp_q.size() > 0) ? exp_q.pop_front() : ~exp;
    check({tag, "_result"}, hilo_res_o, e);
    r0 = hilo_res_o;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_held"}, {63'(hilo_res_o ^ r0), hilo_valid_o}, 64'd1);
    end
    pipe_holdE = 1'b0;
    div_reqE = 1'b0;
    tick();
    check({tag, "_valid_drop"}, 64'(hilo_valid_o), 64'd0);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    check("reset_outputs",
          {stall_div, div_start_o, div_annul_o, div_signed_o, hilo_valid_o, timeout_o},
          64'd0);
    check("reset_data", {div_opa_o, div_opb_o} | hilo_res_o, 64'd0);
    tick(); tick();
    reset = 1'b0;

    do_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 35, 0, 1'b0, "divu_100_7");
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 35, 0, 1'b0,
           "div_m7_2");
    do_div(32'd5, 32'd0, 1'b0, {32'd5, 32'hFFFF_FFFF}, 1, 0, 1'b0, "divu_5_0");

    // Request killed by flush in IDLE is ignored
    div_reqE = 1'b1; srcaE = 32'd12; srcbE = 32'd4; flushE = 1'b1;
    #1;
    check("flush_idle_stall", 64'(stall_div), 64'd0);
    tick();
    check("flush_idle_start", {div_start_o, stall_div}, 64'd0);
    div_reqE = 1'b0; flushE = 1'b0;
    tick();

    // Flush at BUSY cycle 10
    div_reqE = 1'b1; srcaE = 32'd1000; srcbE = 32'd3; div_signedE = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    check("flush_busy_pre", {div_start_o, stall_div}, 64'd3);
    flushE = 1'b1; div_reqE = 1'b0;
    tick();
    flushE = 1'b0;
    check("flush_annul", {div_annul_o, div_start_o, stall_div, hilo_valid_o}, 64'd8);
    tick();
    check("flush_annul_once", {div_annul_o, hilo_valid_o}, 64'd0);
    do_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 35, 0, 1'b0, "divu_9_3");

    // Held in DONE, then back-to-back divide in the first IDLE cycle
    do_div(32'd20, 32'd6, 1'b0, {32'd2, 32'd3}, 35, 3, 1'b0, "hold3");
    do_div(32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 35, 0, 1'b0, "b2b");

    // Watchdog
    ready_en = 1'b0;
    check("timeout_clear", 64'(timeout_o), 64'd0);
    do_div(32'd77, 32'd7, 1'b0, 64'd0, 41, 0, 1'b1, "watchdog");
    check("timeout_sticky", 64'(timeout_o), 64'd1);

    // Asynchronous reset mid-BUSY
    div_reqE = 1'b1; srcaE = 32'd8; srcbE = 32'd2;
    for (int i = 0; i < 5; i++) tick();
    check("busy_before_reset", {timeout_o, div_start_o, stall_div}, 64'd7);
    #2 reset = 1'b1;
    #1;
    check("async_reset_ctl",
          {stall_div, div_start_o, div_annul_o, div_signed_o, hilo_valid_o, timeout_o},
          64'd0);
    check("async_reset_data", {div_opa_o, div_opb_o} | hilo_res_o, 64'd0);
    div_reqE = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_annul", {div_annul_o, div_start_o}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
